// File: rtl/usb_rx_pkg.sv
// Shared definitions for the full-speed USB receive front end:
// line-state encodings, receiver FSM states and SYNC constants.
package usb_rx_pkg;

   // Line state is {D+, D-} after synchronisation
   localparam logic [1:0] LS_J   = 2'b10;
   localparam logic [1:0] LS_K   = 2'b01;
   localparam logic [1:0] LS_SE0 = 2'b00;
   localparam logic [1:0] LS_SE1 = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      DATA,
      EOP,
      ABORT
   } rx_state_t;

   // Newest decoded bit enters at the MSB, so KJKJKJKK reads 1000_0000
   localparam logic [7:0] SYNC_PATTERN      = 8'b1000_0000;
   localparam int         SYNC_TIMEOUT_BITS = 16;

endpackage

// File: rtl/usb_rx_dpll.sv
// Line synchroniser and bit-timing recovery for the USB receiver.
// Ports: clk_48mhz, reset_n (sync, active-low), usb_p_rx/usb_n_rx (async pads)
//        -> line_state {p,n}, bit_strobe (one clock per recovered bit).
// Optional USB_RX_GLITCH_FILTER_EN: accept a line state only after two
// identical consecutive samples, so one-clock glitches never re-phase the DPLL.
module usb_rx_dpll
   import usb_rx_pkg::*;
#(
   parameter int OVERSAMPLE = 4
) (
   input  logic       clk_48mhz,
   input  logic       reset_n,
   input  logic       usb_p_rx,
   input  logic       usb_n_rx,
   output logic [1:0] line_state,
   output logic       bit_strobe
);

   localparam int PW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [PW-1:0] HALF = PW'(OVERSAMPLE / 2);
   localparam logic [PW-1:0] LAST = PW'(OVERSAMPLE - 1);

   logic [1:0]    meta;
   logic [1:0]    sync;
   logic [1:0]    line_d;
   logic [PW-1:0] phase;
   logic [PW-1:0] phase_cur;
   logic          change;

   always_ff @(posedge clk_48mhz) begin
      if (!reset_n) begin
         meta <= LS_J;
         sync <= LS_J;
      end else begin
         meta <= {usb_p_rx, usb_n_rx};
         sync <= meta;
      end
   end

`ifdef USB_RX_GLITCH_FILTER_EN
   logic [1:0] filt;

   always_ff @(posedge clk_48mhz) begin
      if (!reset_n)
         filt <= LS_J;
      else if (meta == sync)
         filt <= sync;
   end

   assign line_state = filt;
`else
   assign line_state = sync;
`endif

   // The clock on which a new state appears is phase 0 of its bit
   assign change     = line_state != line_d;
   assign phase_cur  = change ? '0 : phase;
   assign bit_strobe = phase_cur == HALF;

   always_ff @(posedge clk_48mhz) begin
      if (!reset_n) begin
         line_d <= LS_J;
         phase  <= '0;
      end else begin
         line_d <= line_state;
         phase  <= (phase_cur == LAST) ? '0 : phase_cur + 1'b1;
      end
   end

endmodule

// File: rtl/usb_rx_frontend.sv
// Full-speed USB receive front end: NRZI decode, SYNC detect, bit
// unstuffing, LSB-first byte assembly, EOP/error flagging, bus reset detect.
// Ports: clk_48mhz, reset_n (sync, active-low), usb_p_rx, usb_n_rx
//        -> rx_data[7:0], rx_valid, pkt_start, pkt_end, rx_err, usb_reset.
// Build option USB_RX_GLITCH_FILTER_EN enables the line glitch filter.
module usb_rx_frontend
   import usb_rx_pkg::*;
#(
   parameter int OVERSAMPLE   = 4,
   parameter int MAX_ONES     = 6,
   parameter int RESET_CYCLES = 120
) (
   input  logic       clk_48mhz,
   input  logic       reset_n,
   input  logic       usb_p_rx,
   input  logic       usb_n_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       pkt_start,
   output logic       pkt_end,
   output logic       rx_err,
   output logic       usb_reset
);

   localparam int OW = $clog2(MAX_ONES + 1);
   localparam int CW = $clog2(RESET_CYCLES + 1);
   localparam logic [OW-1:0] ONES_MAX = OW'(MAX_ONES);
   localparam logic [CW-1:0] RC       = CW'(RESET_CYCLES);
   localparam logic [CW-1:0] RC_M1    = CW'(RESET_CYCLES - 1);
   localparam logic [4:0]    SYNC_END = 5'(SYNC_TIMEOUT_BITS - 1);

   logic [1:0]    line_state;
   logic          bit_strobe;
   rx_state_t     state;
   logic [1:0]    prev_ls;
   logic [7:0]    shift;
   logic [7:0]    nshift;
   logic [4:0]    sync_cnt;
   logic [OW-1:0] ones;
   logic [2:0]    bcnt;
   logic [7:0]    sr;
   logic          se0_seen;
   logic [CW-1:0] se0_cnt;
   logic          nrzi;
   logic          is_j;
   logic          is_k;
   logic          is_se0;
   logic          is_se1;

   usb_rx_dpll #(
      .OVERSAMPLE(OVERSAMPLE)
   ) u_dpll (
      .clk_48mhz (clk_48mhz),
      .reset_n   (reset_n),
      .usb_p_rx  (usb_p_rx),
      .usb_n_rx  (usb_n_rx),
      .line_state(line_state),
      .bit_strobe(bit_strobe)
   );

   assign is_j   = line_state == LS_J;
   assign is_k   = line_state == LS_K;
   assign is_se0 = line_state == LS_SE0;
   assign is_se1 = line_state == LS_SE1;
   assign nrzi   = line_state == prev_ls;
   assign nshift = {nrzi, shift[7:1]};

   always_ff @(posedge clk_48mhz) begin
      if (!reset_n) begin
         state     <= IDLE;
         prev_ls   <= LS_J;
         shift     <= 8'hFF;
         sync_cnt  <= '0;
         ones      <= '0;
         bcnt      <= '0;
         sr        <= '0;
         se0_seen  <= 1'b0;
         se0_cnt   <= '0;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         pkt_start <= 1'b0;
         pkt_end   <= 1'b0;
         rx_err    <= 1'b0;
         usb_reset <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         pkt_start <= 1'b0;
         pkt_end   <= 1'b0;
         rx_err    <= 1'b0;

         if (is_se0) begin
            if (se0_cnt != RC)
               se0_cnt <= se0_cnt + 1'b1;
            if (se0_cnt >= RC_M1)
               usb_reset <= 1'b1;
         end else begin
            se0_cnt   <= '0;
            usb_reset <= 1'b0;
         end

         if (usb_reset) begin
            state <= IDLE;
         end else if (bit_strobe) begin
            prev_ls <= line_state;
            unique case (state)
               IDLE: begin
                  if (is_k) begin
                     state    <= SYNC;
                     shift    <= {1'b0, 7'h7F};
                     sync_cnt <= 5'd1;
                  end else if (is_se1) begin
                     rx_err <= 1'b1;
                  end
               end
               SYNC: begin
                  unique case (1'b1)
                     is_se0: state <= IDLE;
                     is_se1: begin
                        rx_err <= 1'b1;
                        state  <= IDLE;
                     end
                     default: begin
                        shift <= nshift;
                        if (nshift == SYNC_PATTERN) begin
                           pkt_start <= 1'b1;
                           ones      <= '0;
                           bcnt      <= '0;
                           state     <= DATA;
                        end else if (sync_cnt == SYNC_END) begin
                           rx_err <= 1'b1;
                           state  <= IDLE;
                        end else begin
                           sync_cnt <= sync_cnt + 1'b1;
                        end
                     end
                  endcase
               end
               DATA: begin
                  se0_seen <= 1'b0;
                  unique case (1'b1)
                     is_se0: state <= EOP;
                     is_se1: begin
                        rx_err <= 1'b1;
                        state  <= ABORT;
                     end
                     default: begin
                        if (ones == ONES_MAX) begin
                           // Bit after a full run of 1s must be a stuffed 0
                           if (nrzi) begin
                              rx_err <= 1'b1;
                              state  <= ABORT;
                           end else begin
                              ones <= '0;
                           end
                        end else begin
                           ones <= nrzi ? ones + 1'b1 : '0;
                           sr   <= nshift_sr(nrzi, sr);
                           bcnt <= bcnt + 1'b1;
                           if (bcnt == 3'd7) begin
                              rx_data  <= nshift_sr(nrzi, sr);
                              rx_valid <= 1'b1;
                           end
                        end
                     end
                  endcase
               end
               EOP: begin
                  unique case (1'b1)
                     is_se0: se0_seen <= 1'b1;
                     is_j && se0_seen: begin
                        pkt_end <= 1'b1;
                        // 0 or 1 dribble bits are tolerated
                        rx_err  <= bcnt >= 3'd2;
                        state   <= IDLE;
                     end
                     default: begin
                        rx_err <= 1'b1;
                        state  <= IDLE;
                     end
                  endcase
               end
               ABORT: begin
                  unique case (1'b1)
                     is_se0: se0_seen <= 1'b1;
                     is_j && se0_seen: begin
                        pkt_end <= 1'b1;
                        state   <= IDLE;
                     end
                     default: se0_seen <= 1'b0;
                  endcase
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   function automatic logic [7:0] nshift_sr(input logic b, input logic [7:0] v);
      return {b, v[7:1]};
   endfunction

endmodule
